// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display sequencer: 16-cycle double-dabble converter plus a 5-digit scanner.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits above D1).
module bcd_display_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        enable,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd_out,
    output logic [4:0]  digit_sel,
    output logic [3:0]  digit_code
);

    // Handshake: load is a request taken only while idle (busy=0); a load seen
    // while busy is dropped, and done pulses once for each accepted load.

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [19:0] acc_adj;

    logic [19:0] presc_q;
    logic [2:0]  idx_q;
    logic [3:0]  sel_nib;
    logic        lz_blank;

    // Add-3 correction on every nibble that would reach 10 or more after doubling.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = value_in;
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = {acc_adj[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_d   = {acc_adj[18:0], bin_q[15]};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= 16'd0;
            acc_q   <= 20'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= 20'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign bcd_out = bcd_q;

    // Scanner is free-running and never looks at the converter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 20'd0;
            idx_q   <= 3'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= 20'd0;
            idx_q   <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end else begin
            presc_q <= presc_q + 20'd1;
        end
    end

    always_comb begin
        digit_sel = 5'b00001;
        sel_nib   = bcd_q[3:0];
        case (idx_q)
            3'd0: begin digit_sel = 5'b00001; sel_nib = bcd_q[3:0];   end
            3'd1: begin digit_sel = 5'b00010; sel_nib = bcd_q[7:4];   end
            3'd2: begin digit_sel = 5'b00100; sel_nib = bcd_q[11:8];  end
            3'd3: begin digit_sel = 5'b01000; sel_nib = bcd_q[15:12]; end
            3'd4: begin digit_sel = 5'b10000; sel_nib = bcd_q[19:16]; end
            default: begin digit_sel = 5'b00001; sel_nib = bcd_q[3:0]; end
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero; D1 never blanks.
    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            3'd1:    lz_blank = (bcd_q[19:4]  == 16'd0);
            3'd2:    lz_blank = (bcd_q[19:8]  == 12'd0);
            3'd3:    lz_blank = (bcd_q[19:12] == 8'd0);
            3'd4:    lz_blank = (bcd_q[19:16] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    assign digit_code = (!enable || lz_blank) ? 4'hF : sel_nib;

endmodule
